// File: rtl/pq_pkg.sv
// Shared definitions for the register-array priority queue family.
package pq_pkg;

  typedef enum logic [1:0] {
    PQ_IDLE,
    PQ_ENQ,
    PQ_DEQ,
    PQ_REPL
  } pq_op_t;

  localparam int PQ_KEY_W = 8;
  localparam int PQ_VAL_W = 8;
  localparam int PQ_DEPTH = 16;

endpackage

// File: rtl/ra_pq_p_cell.sv
// One slot of the sorted register array: holds {valid, key, val} and picks its
// next contents from hold / lower / upper / new. Tie order follows RA_PQ_STABLE_EN.
module ra_pq_p_cell
  import pq_pkg::*;
#(
  parameter int KEY_W    = PQ_KEY_W,
  parameter int VAL_W    = PQ_VAL_W,
  parameter int E_W      = 1 + KEY_W + VAL_W,
  parameter bit IS_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  pq_op_t         op,
  input  logic [E_W-1:0] lower_e,
  input  logic [E_W-1:0] upper_e,
  input  logic [E_W-1:0] new_e,
  input  logic           lower_gt,
  input  logic           lower_ge,
  output logic [E_W-1:0] entry,
  output logic           gt,
  output logic           ge
);

  typedef struct packed {
    logic             v;
    logic [KEY_W-1:0] k;
    logic [VAL_W-1:0] d;
  } entry_t;

  entry_t own_q, nxt, lo, up, nw;
  logic   ins_own, ins_lo, ins_up;
  logic   unused_cmp;

  assign lo = lower_e;
  assign up = upper_e;
  assign nw = new_e;

  assign gt = own_q.k > nw.k;
  assign ge = own_q.k >= nw.k;

  // "ins" = the new entry belongs at or below this slot (invalid slots always qualify)
`ifdef RA_PQ_STABLE_EN
  assign ins_own = !own_q.v || gt;
  assign ins_lo  = !lo.v || lower_gt;
  assign ins_up  = !up.v || (up.k > nw.k);
`else
  assign ins_own = !own_q.v || ge;
  assign ins_lo  = !lo.v || lower_ge;
  assign ins_up  = !up.v || (up.k >= nw.k);
`endif

  assign unused_cmp = lower_gt ^ lower_ge;

  always_comb begin
    nxt = own_q;
    case (op)
      PQ_ENQ: begin
        if (ins_own) nxt = ins_lo ? lo : nw;
      end
      PQ_DEQ: nxt = up;
      PQ_REPL: begin
        // Slot 0 is consumed, so the array is the upper-shifted copy with the new key merged in
        if (!ins_up)                   nxt = up;
        else if (ins_own && !IS_FIRST) nxt = own_q;
        else                           nxt = nw;
      end
      default: nxt = own_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) own_q <= '0;
    else        own_q <= nxt;
  end

  assign entry = own_q;

endmodule

// File: rtl/ra_pq_p.sv
// Parametrised register-array min-priority queue (DEPTH sorted slots, one-cycle ops).
// Optional macro RA_PQ_STABLE_EN selects FIFO order among equal keys (LIFO otherwise).
module ra_pq_p
  import pq_pkg::*;
#(
  parameter int KEY_W = PQ_KEY_W,
  parameter int VAL_W = PQ_VAL_W,
  parameter int DEPTH = PQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [KEY_W-1:0] enq_key,
  input  logic [VAL_W-1:0] enq_val,
  input  logic             deq,
  output logic [KEY_W-1:0] top_key,
  output logic [VAL_W-1:0] top_val,
  output logic             top_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam int E_W = 1 + KEY_W + VAL_W;

  logic [E_W-1:0] ent [DEPTH];
  logic           gt_w [DEPTH];
  logic           ge_w [DEPTH];
  logic [E_W-1:0] new_e;
  pq_op_t         op;
  logic           unused_last;

  assign new_e = {1'b1, enq_key, enq_val};
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Illegal requests degrade to a safe op; replace on empty acts as a plain enqueue
  always_comb begin
    op = PQ_IDLE;
    case ({enq, deq})
      2'b10:   op = full  ? PQ_IDLE : PQ_ENQ;
      2'b01:   op = empty ? PQ_IDLE : PQ_DEQ;
      2'b11:   op = empty ? PQ_ENQ  : PQ_REPL;
      default: op = PQ_IDLE;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [E_W-1:0] lower_e, upper_e;
    logic           lower_gt, lower_ge;

    if (i == 0) begin : g_lo_edge
      // Valid sentinel that never accepts the insert
      assign lower_e  = {1'b1, {(E_W-1){1'b0}}};
      assign lower_gt = 1'b0;
      assign lower_ge = 1'b0;
    end else begin : g_lo
      assign lower_e  = ent[i-1];
      assign lower_gt = gt_w[i-1];
      assign lower_ge = ge_w[i-1];
    end

    if (i == DEPTH - 1) begin : g_up_edge
      assign upper_e = '0;
    end else begin : g_up
      assign upper_e = ent[i+1];
    end

    ra_pq_p_cell #(
      .KEY_W   (KEY_W),
      .VAL_W   (VAL_W),
      .E_W     (E_W),
      .IS_FIRST(i == 0)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (op),
      .lower_e (lower_e),
      .upper_e (upper_e),
      .new_e   (new_e),
      .lower_gt(lower_gt),
      .lower_ge(lower_ge),
      .entry   (ent[i]),
      .gt      (gt_w[i]),
      .ge      (ge_w[i])
    );
  end

  assign unused_last = gt_w[DEPTH-1] ^ ge_w[DEPTH-1] ^ ent[0][E_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= enq && !deq && full;
      udf <= deq && empty;
      case (op)
        PQ_ENQ:  count <= count + 1'b1;
        PQ_DEQ:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign top_key   = ent[0][E_W-2 -: KEY_W];
  assign top_val   = ent[0][VAL_W-1:0];
  assign top_valid = !empty;

endmodule
